// File: rtl/timer_seq_ctrl.sv
// Interval-table sequencer driving the single-interval pulse timer.
// Optional macro SEQ_LOOP_EN adds loop_en for repeating the table.
module timer_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          timeclk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW:0]   seq_len,
  input  logic          start,
  input  logic          abort,
`ifdef SEQ_LOOP_EN
  input  logic          loop_en,
`endif
  input  logic          sigtimeup,
  output logic          timer_rst,
  output logic [15:0]   timer_datain,
  output logic          timer_work,
  output logic          gate,
  output logic [AW-1:0] seg_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_RUN, S_NEXT, S_DONE
  } state_t;

  localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);

  logic [15:0]   tbl [DEPTH];
  state_t        state, n_state;
  logic [AW:0]   len, n_len, len_c;
  logic [AW-1:0] n_seg, nxt_idx;
  logic [15:0]   n_din;
  logic          n_rst, n_work, n_gate;
  logic          n_busy, n_done;
  logic          last, lp;

`ifdef SEQ_LOOP_EN
  assign lp = loop_en;
`else
  assign lp = 1'b0;
`endif

  assign len_c   = (seq_len > DMAX) ? DMAX : seq_len;
  assign last    = ({1'b0, seg_idx} == len - (AW+1)'(1));
  assign nxt_idx = last ? '0 : seg_idx + AW'(1);

  // Table is never reset so it survives reset and abort
  always_ff @(posedge timeclk) begin
    if (wr_en && !busy) tbl[wr_addr] <= wr_data;
  end

  always_comb begin
    n_state = state;
    n_len   = len;
    n_seg   = seg_idx;
    n_din   = timer_datain;
    n_rst   = timer_rst;
    n_work  = timer_work;
    n_gate  = gate;
    n_busy  = busy;
    n_done  = 1'b0;
    if (abort) begin
      n_state = S_IDLE;
      n_rst   = 1'b1;
      n_work  = 1'b1;
      n_gate  = 1'b0;
      n_busy  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          n_rst  = 1'b1;
          n_work = 1'b1;
          n_gate = 1'b0;
          n_busy = 1'b0;
          if (start) begin
            n_seg = '0;
            if (len_c == '0) begin
              n_state = S_DONE;
              n_done  = 1'b1;
            end else begin
              n_state = S_LOAD;
              n_len   = len_c;
              n_busy  = 1'b1;
              n_din   = tbl[0];
              n_gate  = 1'b1;
            end
          end
        end
        S_LOAD: begin
          n_state = S_ARM;
          n_rst   = 1'b0;
          n_work  = 1'b0;
        end
        S_ARM: n_state = S_RUN;
        S_RUN: begin
          if (sigtimeup) begin
            n_state = S_NEXT;
            n_rst   = 1'b1;
            n_work  = 1'b1;
          end
        end
        S_NEXT: begin
          if (last && !lp) begin
            n_state = S_DONE;
            n_done  = 1'b1;
            n_busy  = 1'b0;
            n_gate  = 1'b0;
          end else begin
            n_state = S_LOAD;
            n_seg   = nxt_idx;
            n_din   = tbl[nxt_idx];
            n_gate  = ~nxt_idx[0];
          end
        end
        S_DONE: n_state = S_IDLE;
        default: n_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge timeclk) begin
    if (reset) begin
      state        <= S_IDLE;
      len          <= '0;
      seg_idx      <= '0;
      timer_datain <= '0;
      timer_rst    <= 1'b1;
      timer_work   <= 1'b1;
      gate         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= n_state;
      len          <= n_len;
      seg_idx      <= n_seg;
      timer_datain <= n_din;
      timer_rst    <= n_rst;
      timer_work   <= n_work;
      gate         <= n_gate;
      busy         <= n_busy;
      done         <= n_done;
    end
  end

endmodule
